// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes/InvSubBytes engine: LANES byte S-boxes cover the 128-bit state
// in 16/LANES beats, with valid/ready handshakes on both sides and a per-block latched mode.
module sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clear_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] sb_i,
    input  logic         enc_or_dec_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] sb_o,
    output logic         busy_o
);

    localparam int NBEATS = 16 / LANES;
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_iter: LANES must be one of 1, 2, 4, 8, 16");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e             fsm_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [127:0]       data_q;
    logic [127:0]       data_d;
    logic               mode_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [8*LANES-1:0] lane_out;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction

    // Lane gi works on byte cnt*LANES+gi; byte0 sits in the top bits of the state.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] byte_in;
            assign byte_in = data_q[127 - 8*(int'(cnt_q)*LANES + gi) -: 8];
            assign lane_out[8*gi +: 8] = mode_q ? sbox_fwd(byte_in) : sbox_inv(byte_in);
        end
    endgenerate

    always_comb begin
        data_d = data_q;
        for (int l = 0; l < LANES; l++) begin
            data_d[127 - 8*(int'(cnt_q)*LANES + l) -: 8] = lane_out[8*l +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            fsm_q       <= S_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            mode_q      <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (clear_i) begin
            fsm_q       <= S_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        data_q     <= sb_i;
                        mode_q     <= enc_or_dec_i;
                        cnt_q      <= '0;
                        fsm_q      <= S_BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_BUSY: begin
                    data_q <= data_d;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_q       <= '0;
                        fsm_q       <= S_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // in_ready only rises after this edge, so no same-cycle re-accept.
                    if (out_ready_i) begin
                        fsm_q       <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign sb_o        = data_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter: one instance per legal LANES value (index k -> LANES=1<<k),
// with a table-driven reference model for the randomized backpressure run on LANES=4.
module tb_sub_bytes_iter;

    localparam logic [2047:0] SBOX_HEX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] ALL63 = {16{8'h63}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic [4:0]   in_valid = '0;
    logic [4:0]   out_ready = '0;
    logic [4:0]   in_ready;
    logic [4:0]   out_valid;
    logic [4:0]   busy;
    logic [127:0] sb_in = '0;
    logic         mode = 1'b1;
    logic [127:0] sb_out [5];

    int errors = 0;
    int checks = 0;

    logic [7:0] sbox_t [256];
    logic [7:0] inv_t  [256];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 5; gi++) begin : g_dut
        sub_bytes_iter #(.LANES(1 << gi)) u_dut (
            .clk_i       (clk),
            .rst_n_i     (rst_n),
            .clear_i     (clear),
            .in_valid_i  (in_valid[gi]),
            .in_ready_o  (in_ready[gi]),
            .sb_i        (sb_in),
            .enc_or_dec_i(mode),
            .out_valid_o (out_valid[gi]),
            .out_ready_i (out_ready[gi]),
            .sb_o        (sb_out[gi]),
            .busy_o      (busy[gi])
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic m);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            b = d[127 - 8*i -: 8];
            r[127 - 8*i -: 8] = m ? sbox_t[b] : inv_t[b];
        end
        return r;
    endfunction

    task automatic accept(input int k, input logic [127:0] d, input logic m);
        int t;
        t = 0;
        while (!in_ready[k] && t < 64) begin
            @(negedge clk);
            t++;
        end
        in_valid[k] = 1'b1;
        sb_in = d;
        mode = m;
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, output logic [127:0] res, output int lat);
        lat = 0;
        while (!out_valid[k] && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        res = sb_out[k];
    endtask

    task automatic handshake(input int k);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    initial begin
        logic [2047:0] tab;
        logic [127:0]  res;
        logic [127:0]  held;
        logic [127:0]  q [$];
        int lat;
        int accepts;
        int outs;
        int cyc;

        tab = SBOX_HEX;
        for (int i = 0; i < 256; i++) begin
            sbox_t[i] = tab[2047 - 8*i -: 8];
            inv_t[sbox_t[i]] = i[7:0];
        end

        // Step 1: reset state, then enc of zero on LANES=4.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_in_ready_all", 128'(in_ready), 128'h1f);
        chk("rst_out_valid_all", 128'(out_valid), 128'h0);
        chk("rst_busy_all", 128'(busy), 128'h0);
        chk("rst_sb_o", sb_out[2], 128'h0);
        accept(2, 128'h0, 1'b1);
        chk("busy_after_accept", 128'({busy[2], in_ready[2]}), 128'b10);
        wait_out(2, res, lat);
        chk("lat_lanes4", 128'(lat), 128'd4);
        chk("enc_zero", res, ALL63);
        handshake(2);
        chk("idle_after_hs", 128'({in_ready[2], out_valid[2]}), 128'b10);
        $display("step1 enc zero: sb_o=%h lat=%0d", res, lat);

        // Step 2: FIPS vector enc then dec for every LANES value.
        for (int k = 0; k < 5; k++) begin
            accept(k, PT, 1'b1);
            wait_out(k, res, lat);
            handshake(k);
            chk($sformatf("enc_vec_k%0d", k), res, CT);
            chk($sformatf("lat_k%0d", k), 128'(lat), 128'(16 >> k));
            $display("step2 enc LANES=%0d: sb_o=%h lat=%0d", 1 << k, res, lat);
            accept(k, CT, 1'b0);
            wait_out(k, res, lat);
            handshake(k);
            chk($sformatf("dec_vec_k%0d", k), res, PT);
            $display("step2 dec LANES=%0d: sb_o=%h", 1 << k, res);
        end

        // Step 3: output held stable under backpressure while inputs wiggle.
        accept(2, PT, 1'b1);
        wait_out(2, held, lat);
        chk("bp_initial", held, CT);
        for (int i = 0; i < 5; i++) begin
            sb_in = {$urandom, $urandom, $urandom, $urandom};
            in_valid[2] = i[0];
            @(negedge clk);
            chk($sformatf("bp_hold_%0d", i), {out_valid[2], in_ready[2], sb_out[2][125:0]},
                {1'b1, 1'b0, CT[125:0]});
        end
        in_valid[2] = 1'b0;
        handshake(2);
        chk("bp_release", 128'({in_ready[2], out_valid[2]}), 128'b10);
        $display("step3 backpressure: held=%h", held);

        // Step 4: mode toggled after a dec accept must not affect the block.
        accept(2, ALL63, 1'b0);
        mode = 1'b1;
        sb_in = {4{32'hdeadbeef}};
        wait_out(2, res, lat);
        handshake(2);
        chk("latched_mode", res, 128'h0);
        $display("step4 latched mode: sb_o=%h", res);

        // Step 5: clear, then reset, on the second BUSY beat.
        for (int pass = 0; pass < 2; pass++) begin
            accept(2, PT, 1'b1);
            @(negedge clk);
            if (pass == 0) clear = 1'b1; else rst_n = 1'b0;
            @(negedge clk);
            clear = 1'b0;
            rst_n = 1'b1;
            chk($sformatf("abort_state_%0d", pass), 128'({in_ready[2], out_valid[2], busy[2]}), 128'b100);
            accept(2, {16{8'h53}}, 1'b1);
            wait_out(2, res, lat);
            handshake(2);
            chk($sformatf("after_abort_%0d", pass), res, {16{8'hed}});
            chk($sformatf("after_abort_lat_%0d", pass), 128'(lat), 128'd4);
            $display("step5 abort pass %0d: sb_o=%h lat=%0d", pass, res, lat);
        end

        // Step 6: random blocks and modes with random backpressure on LANES=4.
        accepts = 0;
        outs = 0;
        cyc = 0;
        while ((accepts < 100 || q.size() > 0) && cyc < 5000) begin
            in_valid[2]  = (accepts < 100) && ($urandom_range(0, 1) == 1);
            out_ready[2] = ($urandom_range(0, 3) != 0);
            sb_in = {$urandom, $urandom, $urandom, $urandom};
            mode  = 1'($urandom_range(0, 1));
            if (in_valid[2] && in_ready[2]) begin
                q.push_back(model(sb_in, mode));
                accepts++;
            end
            if (out_valid[2] && out_ready[2]) begin
                held = (q.size() > 0) ? q.pop_front() : 'x;
                chk($sformatf("rand_%0d", outs), sb_out[2], held);
                $display("step6 block %0d: sb_o=%h", outs, sb_out[2]);
                outs++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid[2] = 1'b0;
        out_ready[2] = 1'b0;
        chk("rand_accepts", 128'(accepts), 128'd100);
        chk("rand_outputs", 128'(outs), 128'(accepts));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
